// File: rtl/output_port_allocator_pkg.sv
// Shared definitions for the per-output switch allocator: mesh channel IDs,
// the default route-field width and the allocator FSM state type.
package output_port_allocator_pkg;

    localparam int DEF_PORT_ID_W = 3;

    localparam logic [2:0] CH_LOCAL = 3'b000;
    localparam logic [2:0] CH_NORTH = 3'b001;
    localparam logic [2:0] CH_SOUTH = 3'b010;
    localparam logic [2:0] CH_EAST  = 3'b011;
    localparam logic [2:0] CH_WEST  = 3'b100;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } alloc_state_e;

endpackage

// File: rtl/output_port_allocator_rr_arbiter.sv
// Combinational round-robin pick: first eligible index at or above rr_ptr,
// wrapping around, reported both one-hot and as a binary index.
module noc_rr_arbiter #(
    parameter int N     = 5,
    parameter int IDX_W = 3
) (
    input  logic [N-1:0]     eligible,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [N-1:0]     winner,
    output logic [IDX_W-1:0] winner_idx,
    output logic             any_eligible
);

    int   pos_s;
    logic found_s;

    // Scan N positions starting at rr_ptr; the first hit wins.
    always_comb begin
        pos_s      = 0;
        found_s    = 1'b0;
        winner     = '0;
        winner_idx = '0;
        for (int k = 0; k < N; k++) begin
            pos_s = int'(rr_ptr) + k;
            if (pos_s >= N) begin
                pos_s = pos_s - N;
            end else begin
                pos_s = pos_s;
            end
            if (!found_s && eligible[pos_s]) begin
                found_s       = 1'b1;
                winner[pos_s] = 1'b1;
                winner_idx    = IDX_W'(pos_s);
            end else begin
                found_s = found_s;
            end
        end
    end

    assign any_eligible = found_s;

endmodule

// File: rtl/output_port_allocator.sv
// Per-output switch allocator: round-robin packet-granular grant with a
// downstream credit counter gating each flit transfer.
module output_port_allocator
    import output_port_allocator_pkg::*;
#(
    parameter int                   NUM_PORTS = 5,
    parameter int                   PORT_ID_W = DEF_PORT_ID_W,
    parameter logic [PORT_ID_W-1:0] PORT_ID   = PORT_ID_W'(CH_NORTH),
    parameter int                   BUF_DEPTH = 4,
    localparam int                  CNT_W     = $clog2(BUF_DEPTH + 1),
    localparam int                  IDX_W     = $clog2(NUM_PORTS)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_PORTS-1:0]           req,
    input  logic [NUM_PORTS*PORT_ID_W-1:0] rout_port,
    input  logic [NUM_PORTS-1:0]           tail,
    input  logic                           credit_in,
    output logic [NUM_PORTS-1:0]           grant,
    output logic [IDX_W-1:0]               grant_id,
    output logic                           xfer,
    output logic [CNT_W-1:0]               credits,
    output logic                           credit_err
);

    localparam logic [CNT_W-1:0] CREDIT_MAX = CNT_W'(BUF_DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_PORTS - 1);

    alloc_state_e           state_r;
    alloc_state_e           state_nxt_s;
    logic [NUM_PORTS-1:0]   grant_r;
    logic [IDX_W-1:0]       grant_id_r;
    logic [IDX_W-1:0]       rr_ptr_r;
    logic [CNT_W-1:0]       credits_r;
    logic                   credit_err_r;

    logic [NUM_PORTS-1:0]   eligible_s;
    logic [NUM_PORTS-1:0]   win_s;
    logic [IDX_W-1:0]       win_idx_s;
    logic                   any_s;
    logic                   locked_s;
    logic                   xfer_s;
    logic                   release_s;
    logic [IDX_W-1:0]       ptr_after_s;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_elig
        assign eligible_s[i] = req[i] && (rout_port[i*PORT_ID_W +: PORT_ID_W] == PORT_ID);
    end

    noc_rr_arbiter #(
        .N     (NUM_PORTS),
        .IDX_W (IDX_W)
    ) u_arb (
        .eligible     (eligible_s),
        .rr_ptr       (rr_ptr_r),
        .winner       (win_s),
        .winner_idx   (win_idx_s),
        .any_eligible (any_s)
    );

    // While locked only the winner's request/tail matter; an abort releases
    // even with no credits, a tail releases only when it actually transfers.
    assign locked_s    = (state_r == ST_LOCKED);
    assign xfer_s      = locked_s && req[grant_id_r] && (credits_r != '0);
    assign release_s   = locked_s && (!req[grant_id_r] || (xfer_s && tail[grant_id_r]));
    assign ptr_after_s = (grant_id_r == LAST_IDX) ? '0 : grant_id_r + IDX_W'(1);

    // Next-state logic for the allocation FSM.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (any_s) begin
                    state_nxt_s = ST_LOCKED;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOCKED: begin
                if (release_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_LOCKED;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM state, grant register and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            grant_r    <= '0;
            grant_id_r <= '0;
            rr_ptr_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            if ((state_r == ST_IDLE) && any_s) begin
                grant_r    <= win_s;
                grant_id_r <= win_idx_s;
            end else if (release_s) begin
                grant_r    <= '0;
                grant_id_r <= '0;
                rr_ptr_r   <= ptr_after_s;
            end
        end
    end

    // Downstream credit counter with sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            credits_r    <= CREDIT_MAX;
            credit_err_r <= 1'b0;
        end else begin
            case ({xfer_s, credit_in})
                2'b10: credits_r <= credits_r - CNT_W'(1);
                2'b01: begin
                    if (credits_r == CREDIT_MAX) begin
                        credit_err_r <= 1'b1;
                    end else begin
                        credits_r <= credits_r + CNT_W'(1);
                    end
                end
                default: credits_r <= credits_r;
            endcase
        end
    end

    assign grant      = grant_r;
    assign grant_id   = grant_id_r;
    assign xfer       = xfer_s;
    assign credits    = credits_r;
    assign credit_err = credit_err_r;

endmodule
